dac_spi_driver: RTL and testbench

// - Serialises one 12-bit sample plus a channel select into a 16-bit SPI frame for the

---
 rtl/dac_pkg.sv | 12 +
 rtl/sclk_tick_gen.sv | 19 +
 rtl/dac_spi_driver.sv | 80 ++++++++
 tb/tb_dac_spi_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared FSM states, frame layout and fixed DAC config bits
package dac_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, CS_REL, LDAC, DONE} state_t;
    localparam int FRAME_CH = 15;
    localparam int FRAME_BUF = 14;
    localparam int FRAME_GA_N = 13;
    localparam int FRAME_SHDN_N = 12;
    localparam int FRAME_DATA_MSB = 11;
    localparam logic CFG_BUF = 1'b0;
    localparam logic CFG_GA_N = 1'b1;
    localparam logic CFG_SHDN_N = 1'b1;
endpackage

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: free-running divider that ticks once every CLK_DIV cycles
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    // count up and wrap on tick; clear holds phase at zero while idle
    always_ff @(posedge clk) begin
        if (!rst || clear) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises a channel+code frame to an MCP4922-style DAC and pulses LDAC
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_BITS = 12,
    parameter int FRAME_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 channel,
    output logic                 busy,
    output logic                 done,
    output logic                 dac_cs_n,
    output logic                 dac_ldac_n,
    output logic                 dac_din,
    output logic                 dac_sclk
);
    localparam int BW = $clog2(FRAME_BITS);
    state_t state, state_n;
    logic [FRAME_BITS-1:0] sreg, sreg_n;
    logic [BW-1:0] bit_cnt, cnt_n;
    logic tick;
    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .clear(state == IDLE),
        .tick(tick)
    );
    // next state; the frame shifts left after each high phase so its MSB is always the next bit
    always_comb begin
        state_n = state;
        sreg_n = sreg;
        cnt_n = bit_cnt;
        unique case (state)
            IDLE: if (start) begin
                state_n = SETUP;
                sreg_n = {channel, CFG_BUF, CFG_GA_N, CFG_SHDN_N, data_in};
                cnt_n = BW'(FRAME_BITS - 1);
            end
            SETUP: state_n = tick ? SHIFT_LO : state;
            SHIFT_LO: state_n = tick ? SHIFT_HI : state;
            SHIFT_HI: if (tick) begin
                state_n = bit_cnt == '0 ? CS_REL : SHIFT_LO;
                cnt_n = bit_cnt - 1'b1;
                sreg_n = sreg << 1;
            end
            CS_REL: state_n = tick ? LDAC : state;
            LDAC: state_n = tick ? DONE : state;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state and pins registered from the next state so every pin lines up with its state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sreg <= '0;
            bit_cnt <= '0;
            dac_cs_n <= 1'b1;
            dac_ldac_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_din <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            sreg <= sreg_n;
            bit_cnt <= cnt_n;
            dac_cs_n <= !(state_n inside {SETUP, SHIFT_LO, SHIFT_HI});
            dac_ldac_n <= state_n != LDAC;
            dac_sclk <= state_n == SHIFT_HI;
            dac_din <= (state_n inside {SETUP, SHIFT_LO}) ? sreg_n[FRAME_BITS-1] : dac_din;
            busy <= !(state_n inside {IDLE, DONE});
            done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: directed + random frames on CLK_DIV=2 and CLK_DIV=1 builds, checked by an SPI monitor
module tb_dac_spi_driver;
    logic clk = 1'b0;
    logic [1:0] rst_v, start_v, ch_v, busy_w, done_w, cs_w, ldac_w, din_w, sclk_w;
    logic [11:0] data_v [2];
    int cyc = 0;
    int compared = 0;
    int fails = 0;
    logic [1:0] sclk_p, din_p, cs_p, ldac_p;
    int run [2], bits [2], ldac_pulses [2], done_cnt [2], done_cyc [2], cs_hi [2], ldac_lo [2];
    logic [15:0] cap [2];

    dac_spi_driver #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data_in(data_v[0]), .channel(ch_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .dac_cs_n(cs_w[0]), .dac_ldac_n(ldac_w[0]),
        .dac_din(din_w[0]), .dac_sclk(sclk_w[0])
    );
    dac_spi_driver #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data_in(data_v[1]), .channel(ch_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .dac_cs_n(cs_w[1]), .dac_ldac_n(ldac_w[1]),
        .dac_din(din_w[1]), .dac_sclk(sclk_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int divof(input int d);
        return d == 0 ? 2 : 1;
    endfunction

    function automatic logic [15:0] ref_frame(input logic ch, input logic [11:0] code);
        return 16'((int'(ch) << 15) + (3 << 12) + int'(code));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // pin-level SPI/LDAC monitor for both builds
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_v[d]) begin
                if (!cs_w[d] && cs_p[d]) begin
                    run[d] = 1;
                    bits[d] = 0;
                    cap[d] = '0;
                end else if (sclk_w[d] != sclk_p[d]) begin
                    chk(sclk_p[d] ? "sclk_high_len" : "sclk_low_len", run[d],
                        sclk_p[d] ? divof(d) : (bits[d] == 0 ? 2 * divof(d) : divof(d)));
                    run[d] = 1;
                    if (sclk_w[d]) begin
                        chk("din_stable_at_rise", din_w[d], din_p[d]);
                        cap[d] = {cap[d][14:0], din_w[d]};
                        bits[d]++;
                    end
                end else run[d]++;
                if (cs_w[d] != cs_p[d]) chk("sclk_low_at_cs_edge", sclk_w[d], 0);
                if (cs_w[d] && !cs_p[d]) cs_hi[d] = cyc;
                if (!ldac_w[d] && ldac_p[d]) begin
                    ldac_pulses[d]++;
                    ldac_lo[d] = cyc;
                    chk("ldac_after_cs", cyc - cs_hi[d], divof(d));
                    chk("cs_high_during_ldac", cs_w[d], 1);
                end
                if (ldac_w[d] && !ldac_p[d]) chk("ldac_len", cyc - ldac_lo[d], divof(d));
                if (done_w[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                end
            end
            sclk_p[d] = sclk_w[d];
            din_p[d] = din_w[d];
            cs_p[d] = cs_w[d];
            ldac_p[d] = ldac_w[d];
        end
    end

    task automatic send(input int d, input logic [11:0] dat, input logic ch, input int rej, input bit poke);
        int lat, acc, t, dc0, lp0;
        lat = 35 * divof(d);
        dc0 = done_cnt[d];
        lp0 = ldac_pulses[d];
        start_v[d] = 1'b1;
        data_v[d] = dat;
        ch_v[d] = ch;
        acc = cyc + 1;
        step;
        start_v[d] = 1'b0;
        t = 0;
        while (done_cnt[d] == dc0 && t < 4 * lat) begin
            if (t == 0) chk("busy_in_frame", busy_w[d], 1);
            if (rej != 0 && cyc == acc + rej) begin
                start_v[d] = 1'b1;
                data_v[d] = 12'h123;
            end else begin
                start_v[d] = 1'b0;
                data_v[d] = 12'($urandom);
                ch_v[d] = 1'($urandom);
            end
            step;
            t++;
        end
        start_v[d] = 1'b0;
        chk("done_seen", done_cnt[d] - dc0, 1);
        chk("done_latency", done_cyc[d] - acc, lat);
        chk("frame", cap[d], ref_frame(ch, dat));
        chk("bit_count", bits[d], 16);
        chk("ldac_pulses", ldac_pulses[d] - lp0, 1);
        chk("busy_low_at_done", busy_w[d], 0);
        if (poke) begin
            start_v[d] = 1'b1;
            data_v[d] = 12'($urandom);
            step;
            start_v[d] = 1'b0;
            repeat (3) step;
            chk("done_cycle_start_ignored_busy", busy_w[d], 0);
            chk("done_cycle_start_ignored_cs", cs_w[d], 1);
        end else step;
    endtask

    initial begin
        int acc, dc0, lp0, d;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; bits[i] = 0; ldac_pulses[i] = 0; done_cnt[i] = 0;
            done_cyc[i] = 0; cs_hi[i] = 0; ldac_lo[i] = 0; cap[i] = '0; data_v[i] = '0;
        end
        sclk_p = '0; din_p = '0; cs_p = '1; ldac_p = '1;
        rst_v = 2'b00;
        start_v = 2'b11;
        ch_v = 2'b00;
        repeat (4) step;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", cs_w[i], 1);
            chk("rst_ldac_n", ldac_w[i], 1);
            chk("rst_sclk", sclk_w[i], 0);
            chk("rst_din", din_w[i], 0);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
        end
        rst_v = 2'b11;
        start_v = 2'b00;
        step;
        send(0, 12'hA5C, 1'b1, 0, 1'b0);
        send(0, 12'hFFF, 1'b0, 0, 1'b0);
        send(0, 12'h3C3, 1'b1, 10, 1'b0);
        send(0, 12'h123, 1'b0, 0, 1'b1);
        dc0 = done_cnt[0];
        lp0 = ldac_pulses[0];
        start_v[0] = 1'b1;
        data_v[0] = 12'h5A5;
        ch_v[0] = 1'b1;
        acc = cyc + 1;
        step;
        start_v[0] = 1'b0;
        while (cyc < acc + 30) step;
        rst_v[0] = 1'b0;
        step;
        chk("abort_cs_n", cs_w[0], 1);
        chk("abort_ldac_n", ldac_w[0], 1);
        chk("abort_sclk", sclk_w[0], 0);
        chk("abort_din", din_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_done", done_w[0], 0);
        rst_v[0] = 1'b1;
        repeat (80) step;
        chk("abort_no_done", done_cnt[0] - dc0, 0);
        chk("abort_no_ldac", ldac_pulses[0] - lp0, 0);
        send(0, 12'h001, 1'b0, 0, 1'b0);
        send(1, 12'h800, 1'b0, 0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            d = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step;
            send(d, 12'($urandom), 1'($urandom),
                 $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 35 * divof(d) - 1)) : 0,
                 $urandom_range(0, 3) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end
endmodule
